// File: rtl/sounder_frame_sequencer_if.sv
// AXI-Stream style sample bus used on both sides of the frame sequencer.
// The master drives data/valid/last and the slave drives ready.
interface sounder_frame_sequencer_if #(
    parameter int DATA_W = 16
) ();
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master (output tdata, output tvalid, output tlast, input  tready);
    modport slave  (input  tdata, input  tvalid, input  tlast, output tready);
endinterface

// File: rtl/sounder_frame_sequencer.sv
// Frames the ADC sample stream for the correlator: D passed-through samples, then P zeros,
// with tlast on the final beat. Runs N frames (or until abort when N is 0) per start pulse.
module sounder_frame_sequencer #(
    parameter int DATA_W = 16,
    parameter int LEN_W  = 8,
    parameter int CNT_W  = 16
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      start_i,
    input  logic                      abort_i,
    input  logic [LEN_W-1:0]          cfg_data_len_i,
    input  logic [LEN_W-1:0]          cfg_pad_len_i,
    input  logic [CNT_W-1:0]          cfg_num_frames_i,
    sounder_frame_sequencer_if.slave  s_axis,
    sounder_frame_sequencer_if.master m_axis,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      cfg_err_o,
    output logic [CNT_W-1:0]          frame_cnt_o
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DATA  = 3'd1,
        ST_PAD   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [LEN_W:0]    pos_q, pos_d;
    logic [LEN_W-1:0]  d_len_q, d_len_d;
    logic [LEN_W-1:0]  p_len_q, p_len_d;
    logic [CNT_W-1:0]  n_q, n_d;
    logic [CNT_W-1:0]  loaded_q, loaded_d;
    logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic              abort_pend_q, abort_pend_d;
    logic [DATA_W-1:0] tdata_q, tdata_d;
    logic              tvalid_q, tvalid_d;
    logic              tlast_q, tlast_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              cfg_err_q, cfg_err_d;

    logic              load_en_s;
    logic              s_ready_s;
    logic              s_hs_s;
    logic              m_hs_s;
    logic              data_last_s;
    logic              frame_last_s;
    logic [CNT_W-1:0]  loaded_inc_s;
    logic              stop_s;

    assign load_en_s    = !tvalid_q || m_axis.tready;
    assign s_ready_s    = (state_q == ST_DATA) && load_en_s && !abort_pend_q;
    assign s_hs_s       = s_ready_s && s_axis.tvalid;
    assign m_hs_s       = tvalid_q && m_axis.tready;
    assign data_last_s  = (pos_q == ({1'b0, d_len_q} - (LEN_W+1)'(1)));
    assign frame_last_s = (pos_q == ({1'b0, d_len_q} + {1'b0, p_len_q} - (LEN_W+1)'(1)));
    assign loaded_inc_s = loaded_q + CNT_W'(1);
    // A frame boundary ends the run on abort or once the programmed frame count is loaded.
    assign stop_s       = abort_i || abort_pend_q ||
                          ((n_q != CNT_W'(0)) && (loaded_inc_s == n_q));

    assign s_axis.tready = s_ready_s;
    assign m_axis.tdata  = tdata_q;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tlast  = tlast_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign cfg_err_o     = cfg_err_q;
    assign frame_cnt_o   = frame_cnt_q;

    // State and datapath registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= ST_IDLE;
            pos_q        <= '0;
            d_len_q      <= '0;
            p_len_q      <= '0;
            n_q          <= '0;
            loaded_q     <= '0;
            frame_cnt_q  <= '0;
            abort_pend_q <= 1'b0;
            tdata_q      <= '0;
            tvalid_q     <= 1'b0;
            tlast_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pos_q        <= pos_d;
            d_len_q      <= d_len_d;
            p_len_q      <= p_len_d;
            n_q          <= n_d;
            loaded_q     <= loaded_d;
            frame_cnt_q  <= frame_cnt_d;
            abort_pend_q <= abort_pend_d;
            tdata_q      <= tdata_d;
            tvalid_q     <= tvalid_d;
            tlast_q      <= tlast_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    // Next-state, output-register load and counter logic.
    always_comb begin
        state_d      = state_q;
        pos_d        = pos_q;
        d_len_d      = d_len_q;
        p_len_d      = p_len_q;
        n_d          = n_q;
        loaded_d     = loaded_q;
        frame_cnt_d  = frame_cnt_q;
        abort_pend_d = abort_pend_q;
        tdata_d      = tdata_q;
        tvalid_d     = tvalid_q;
        tlast_d      = tlast_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        cfg_err_d    = 1'b0;

        if (m_hs_s) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
        end else begin
            tvalid_d = tvalid_q;
            tlast_d  = tlast_q;
        end

        if (m_hs_s && tlast_q && (frame_cnt_q != {CNT_W{1'b1}})) begin
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
        end else begin
            frame_cnt_d = frame_cnt_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_i && (cfg_data_len_i == LEN_W'(0))) begin
                    cfg_err_d = 1'b1;
                end else if (start_i && !abort_i) begin
                    d_len_d      = cfg_data_len_i;
                    p_len_d      = cfg_pad_len_i;
                    n_d          = cfg_num_frames_i;
                    loaded_d     = '0;
                    frame_cnt_d  = '0;
                    pos_d        = '0;
                    abort_pend_d = 1'b0;
                    busy_d       = 1'b1;
                    state_d      = ST_DATA;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DATA: begin
                abort_pend_d = abort_pend_q | abort_i;
                if (s_hs_s) begin
                    tdata_d  = s_axis.tdata;
                    tvalid_d = 1'b1;
                    tlast_d  = 1'b0;
                    if (data_last_s && (p_len_q == LEN_W'(0))) begin
                        tlast_d  = 1'b1;
                        pos_d    = '0;
                        loaded_d = loaded_inc_s;
                        state_d  = stop_s ? ST_DRAIN : ST_DATA;
                    end else if (data_last_s || abort_i) begin
                        pos_d   = pos_q + (LEN_W+1)'(1);
                        state_d = ST_PAD;
                    end else begin
                        pos_d   = pos_q + (LEN_W+1)'(1);
                        state_d = ST_DATA;
                    end
                end else if (abort_i) begin
                    // Unfilled data positions of this frame become zeros.
                    state_d = ST_PAD;
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PAD: begin
                abort_pend_d = abort_pend_q | abort_i;
                if (load_en_s) begin
                    tdata_d  = '0;
                    tvalid_d = 1'b1;
                    if (frame_last_s) begin
                        tlast_d  = 1'b1;
                        pos_d    = '0;
                        loaded_d = loaded_inc_s;
                        state_d  = stop_s ? ST_DRAIN : ST_DATA;
                    end else begin
                        tlast_d = 1'b0;
                        pos_d   = pos_q + (LEN_W+1)'(1);
                        state_d = ST_PAD;
                    end
                end else begin
                    state_d = ST_PAD;
                end
            end
            ST_DRAIN: begin
                if (load_en_s) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                abort_pend_d = 1'b0;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sounder_frame_sequencer.sv
// Self-checking bench for sounder_frame_sequencer: table of framed runs checked against
// an expected beat list built from the framing rules, plus abort/cfg_err/reset sequences.
module tb_sounder_frame_sequencer;

    typedef struct {
        int d;
        int p;
        int n;
        int rmode;
        int vmode;
        bit restart;
        int exp_beats;
        int exp_frames;
    } vec_t;

    logic        aclk;
    logic        aresetn;
    logic        start;
    logic        abort;
    logic [7:0]  cfg_d;
    logic [7:0]  cfg_p;
    logic [15:0] cfg_n;
    logic        busy;
    logic        done;
    logic        cfg_err;
    logic [15:0] frame_cnt;

    sounder_frame_sequencer_if #(.DATA_W(16)) s_if ();
    sounder_frame_sequencer_if #(.DATA_W(16)) m_if ();

    sounder_frame_sequencer #(.DATA_W(16), .LEN_W(8), .CNT_W(16)) dut (
        .aclk             (aclk),
        .aresetn          (aresetn),
        .start_i          (start),
        .abort_i          (abort),
        .cfg_data_len_i   (cfg_d),
        .cfg_pad_len_i    (cfg_p),
        .cfg_num_frames_i (cfg_n),
        .s_axis           (s_if.slave),
        .m_axis           (m_if.master),
        .busy_o           (busy),
        .done_o           (done),
        .cfg_err_o        (cfg_err),
        .frame_cnt_o      (frame_cnt)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          src_idx  = 0;
    int          cyc      = 0;
    int          last_m_cyc = 0;
    bit          prev_stall = 1'b0;
    logic [15:0] prev_data  = 16'd0;
    bit          last_sv    = 1'b0;
    bit          last_shs   = 1'b0;
    logic [15:0] rx_d[$];
    bit          rx_l[$];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    endtask

    // One clock: drive inputs on the falling edge, then observe what the next rising edge will do.
    task automatic drive_cycle(input bit sv, input bit mr, input bit st, input bit ab);
        @(negedge aclk);
        s_if.tvalid = sv;
        s_if.tdata  = 16'(src_idx);
        s_if.tlast  = 1'b0;
        m_if.tready = mr;
        start       = st;
        abort       = ab;
        #1;
        cyc++;
        if (prev_stall) begin
            chk("hold_valid", 32'(m_if.tvalid), 32'd1);
            chk("hold_data", 32'(m_if.tdata), 32'(prev_data));
        end
        prev_stall = m_if.tvalid && !mr;
        prev_data  = m_if.tdata;
        last_sv    = sv;
        last_shs   = sv && s_if.tready;
        if (last_shs) src_idx++;
        if (m_if.tvalid && mr) begin
            rx_d.push_back(m_if.tdata);
            rx_l.push_back(m_if.tlast);
            last_m_cyc = cyc;
        end
    endtask

    task automatic run_cfg(input vec_t v, input int src0);
        int exp_d[$];
        bit exp_l[$];
        bit seen;
        bit sv;
        bit mr;
        bit st;
        int done_cyc;
        int bad;
        int nb;
        // Expected beats: frame f carries source samples f*D..f*D+D-1, then P zeros.
        for (int f = 0; f < v.n; f++) begin
            for (int i = 0; i < v.d + v.p; i++) begin
                exp_d.push_back(i < v.d ? ((src0 + f * v.d + i) & 32'hFFFF) : 0);
                exp_l.push_back(i == v.d + v.p - 1);
            end
        end
        src_idx = src0;
        rx_d.delete();
        rx_l.delete();
        seen     = 1'b0;
        done_cyc = 0;
        cfg_d = 8'(v.d);
        cfg_p = 8'(v.p);
        cfg_n = 16'(v.n);
        drive_cycle(1'b0, 1'b1, 1'b1, 1'b0);
        for (int c = 0; c < 20000 && !seen; c++) begin
            if (v.vmode == 0) sv = 1'b1;
            else if (last_sv && !last_shs) sv = 1'b1;
            else sv = 1'($urandom_range(0, 1));
            if (v.rmode == 0) mr = 1'b1;
            else if (v.rmode == 1) mr = 1'(cyc % 2);
            else mr = 1'($urandom_range(0, 1));
            st = v.restart && (c == 5);
            if (st) begin
                cfg_d = 8'(v.d + 3);
                cfg_p = 8'(v.p + 2);
                cfg_n = 16'(v.n + 1);
            end
            drive_cycle(sv, mr, st, 1'b0);
            if (c == 0) chk("busy_after_start", 32'(busy), 32'd1);
            if (done) begin
                seen     = 1'b1;
                done_cyc = cyc;
            end
        end
        chk("done_seen", 32'(seen), 32'd1);
        chk("beat_count", 32'(rx_d.size()), 32'(v.exp_beats));
        chk("frame_cnt_at_done", 32'(frame_cnt), 32'(v.exp_frames));
        chk("done_latency", 32'(done_cyc - last_m_cyc), 32'd1);
        bad = 0;
        nb  = (rx_d.size() < exp_d.size()) ? rx_d.size() : exp_d.size();
        for (int i = 0; i < nb; i++) begin
            if (rx_d[i] !== 16'(exp_d[i]) || rx_l[i] !== exp_l[i]) begin
                if (bad == 0)
                    $display("FAIL beat %0d: got data %0d last %0d, expected data %0d last %0d",
                             i, rx_d[i], rx_l[i], exp_d[i], exp_l[i]);
                bad++;
            end
        end
        chk("beat_content_errors", 32'(bad), 32'd0);
        drive_cycle(1'b0, 1'b1, 1'b0, 1'b0);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("busy_after_done", 32'(busy), 32'd0);
    endtask

    vec_t tbl[7];
    bit   seen;

    initial begin
        tbl[0] = '{d: 32,  p: 8,  n: 2, rmode: 0, vmode: 0, restart: 1'b0, exp_beats: 80,  exp_frames: 2};
        tbl[1] = '{d: 32,  p: 8,  n: 2, rmode: 1, vmode: 0, restart: 1'b0, exp_beats: 80,  exp_frames: 2};
        tbl[2] = '{d: 3,   p: 0,  n: 3, rmode: 2, vmode: 2, restart: 1'b0, exp_beats: 9,   exp_frames: 3};
        tbl[3] = '{d: 1,   p: 1,  n: 4, rmode: 2, vmode: 2, restart: 1'b0, exp_beats: 8,   exp_frames: 4};
        tbl[4] = '{d: 8,   p: 3,  n: 2, rmode: 1, vmode: 2, restart: 1'b1, exp_beats: 22,  exp_frames: 2};
        tbl[5] = '{d: 200, p: 55, n: 1, rmode: 2, vmode: 2, restart: 1'b0, exp_beats: 255, exp_frames: 1};
        tbl[6] = '{d: 5,   p: 0,  n: 1, rmode: 0, vmode: 2, restart: 1'b0, exp_beats: 5,   exp_frames: 1};

        aresetn     = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        cfg_d       = 8'd0;
        cfg_p       = 8'd0;
        cfg_n       = 16'd0;
        s_if.tvalid = 1'b0;
        s_if.tdata  = 16'd0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b1;
        #1;
        chk("reset_tvalid", 32'(m_if.tvalid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        drive_cycle(1'b1, 1'b1, 1'b0, 1'b0);
        chk("idle_tdata", 32'(m_if.tdata), 32'd0);
        chk("idle_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("idle_s_tready", 32'(s_if.tready), 32'd0);

        for (int k = 0; k < 7; k++) run_cfg(tbl[k], k * 1000);

        // Abort in continuous mode after ten input samples.
        cfg_d = 8'd4; cfg_p = 8'd0; cfg_n = 16'd0;
        src_idx = 0;
        rx_d.delete();
        rx_l.delete();
        drive_cycle(1'b0, 1'b1, 1'b1, 1'b0);
        for (int c = 0; c < 100 && src_idx < 10; c++) drive_cycle(1'b1, 1'b1, 1'b0, 1'b0);
        drive_cycle(1'b0, 1'b1, 1'b0, 1'b1);
        drive_cycle(1'b1, 1'b1, 1'b0, 1'b0);
        chk("abort_s_tready", 32'(s_if.tready), 32'd0);
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            drive_cycle(1'b1, 1'b1, 1'b0, 1'b0);
            if (done) seen = 1'b1;
        end
        chk("abort_done", 32'(seen), 32'd1);
        chk("abort_samples_used", 32'(src_idx), 32'd10);
        chk("abort_frame_cnt", 32'(frame_cnt), 32'd3);
        chk("abort_beats", 32'(rx_d.size()), 32'd12);
        for (int i = 0; i < rx_d.size() && i < 12; i++) begin
            chk("abort_data", 32'(rx_d[i]), (i < 10) ? 32'(i) : 32'd0);
            chk("abort_last", 32'(rx_l[i]), ((i % 4) == 3) ? 32'd1 : 32'd0);
        end

        // Zero data length is refused.
        cfg_d = 8'd0; cfg_p = 8'd3; cfg_n = 16'd1;
        drive_cycle(1'b1, 1'b1, 1'b1, 1'b0);
        drive_cycle(1'b1, 1'b1, 1'b0, 1'b0);
        chk("cfg_err_pulse", 32'(cfg_err), 32'd1);
        chk("cfg_err_busy", 32'(busy), 32'd0);
        drive_cycle(1'b1, 1'b1, 1'b0, 1'b0);
        chk("cfg_err_width", 32'(cfg_err), 32'd0);
        chk("cfg_err_no_valid", 32'(m_if.tvalid), 32'd0);

        // Asynchronous reset in the middle of the pad section.
        cfg_d = 8'd32; cfg_p = 8'd8; cfg_n = 16'd1;
        src_idx = 0;
        rx_d.delete();
        rx_l.delete();
        drive_cycle(1'b0, 1'b1, 1'b1, 1'b0);
        for (int c = 0; c < 200 && rx_d.size() < 34; c++) drive_cycle(1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge aclk);
        chk("pre_reset_busy", 32'(busy), 32'd1);
        #2;
        aresetn = 1'b0;
        #1;
        chk("arst_tvalid", 32'(m_if.tvalid), 32'd0);
        chk("arst_tlast", 32'(m_if.tlast), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_s_tready", 32'(s_if.tready), 32'd0);
        prev_stall = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        run_cfg('{d: 4, p: 1, n: 1, rmode: 0, vmode: 0, restart: 1'b0, exp_beats: 5, exp_frames: 1}, 100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
